// File: rtl/execute_muldiv_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
// The pipeline side is the master; the unit itself is the slave.
interface execute_muldiv_if #(
  parameter int DWIDTH = 32
);
  logic              em_i_ce;
  logic [2:0]        em_i_op;
  logic [DWIDTH-1:0] em_i_data_rs;
  logic [DWIDTH-1:0] em_i_data_rt;
  logic              em_i_flush;
  logic              em_o_busy;
  logic              em_o_done;
  logic              em_o_div_zero;
  logic [DWIDTH-1:0] em_o_hi;
  logic [DWIDTH-1:0] em_o_lo;

  modport master (
    output em_i_ce, em_i_op, em_i_data_rs, em_i_data_rt, em_i_flush,
    input  em_o_busy, em_o_done, em_o_div_zero, em_o_hi, em_o_lo
  );

  modport slave (
    input  em_i_ce, em_i_op, em_i_data_rs, em_i_data_rt, em_i_flush,
    output em_o_busy, em_o_done, em_o_div_zero, em_o_hi, em_o_lo
  );
endinterface

// File: rtl/execute_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, STEP result bits per cycle.
// Operates on magnitudes; signs are re-applied in a single FIX cycle.
module execute_muldiv #(
  parameter int DWIDTH = 32,
  parameter int STEP   = 1
) (
  input logic             em_i_clk,
  input logic             em_i_rst,
  execute_muldiv_if.slave bus
);
  localparam int N  = DWIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_FIX = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*DWIDTH-1:0] acc_q, acc_d;
  logic [DWIDTH-1:0]   opb_q, opb_d;
  logic [DWIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic                is_div_q, is_div_d, dz_q, dz_d;
  logic                busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;

  logic                op_muldiv, op_signed, op_div, start;
  logic                rs_neg, rt_neg;
  logic [DWIDTH-1:0]   rs_mag, rt_mag;
  logic [DWIDTH+STEP-1:0] mul_sum;
  logic [2*DWIDTH-1:0] mul_next, div_next, prod_fix;
  logic [DWIDTH:0]     rem_t;
  logic [DWIDTH-1:0]   rem_w, quo_w, quo_fix, rem_fix;

  always_comb begin
    op_muldiv = (bus.em_i_op == OP_MULT) || (bus.em_i_op == OP_MULTU) ||
                (bus.em_i_op == OP_DIV)  || (bus.em_i_op == OP_DIVU);
    op_signed = (bus.em_i_op == OP_MULT) || (bus.em_i_op == OP_DIV);
    op_div    = (bus.em_i_op == OP_DIV)  || (bus.em_i_op == OP_DIVU);
    start     = (state_q == S_IDLE) && bus.em_i_ce && !bus.em_i_flush && op_muldiv;
    rs_neg    = op_signed && bus.em_i_data_rs[DWIDTH-1];
    rt_neg    = op_signed && bus.em_i_data_rt[DWIDTH-1];
    rs_mag    = rs_neg ? -bus.em_i_data_rs : bus.em_i_data_rs;
    rt_mag    = rt_neg ? -bus.em_i_data_rt : bus.em_i_data_rt;
  end

  // Multiply: acc = {partial product, unconsumed multiplier}; shifts right STEP bits per cycle.
  always_comb begin
    mul_sum  = {{STEP{1'b0}}, acc_q[2*DWIDTH-1:DWIDTH]}
             + ({{STEP{1'b0}}, opb_q} * {{DWIDTH{1'b0}}, acc_q[STEP-1:0]});
    mul_next = {mul_sum, acc_q[DWIDTH-1:STEP]};
  end

  // Divide: acc = {remainder, dividend/quotient}; remainder after subtraction always fits DWIDTH.
  always_comb begin
    rem_w = acc_q[2*DWIDTH-1:DWIDTH];
    quo_w = acc_q[DWIDTH-1:0];
    rem_t = '0;
    for (int i = 0; i < STEP; i++) begin
      rem_t = {rem_w, quo_w[DWIDTH-1]};
      quo_w = {quo_w[DWIDTH-2:0], 1'b0};
      if (rem_t >= {1'b0, opb_q}) begin
        rem_t    = rem_t - {1'b0, opb_q};
        quo_w[0] = 1'b1;
      end
      rem_w = rem_t[DWIDTH-1:0];
    end
    div_next = {rem_w, quo_w};
  end

  // With a zero divisor the remainder ends up as |rs|, so the sign fix restores rs in HI.
  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[DWIDTH-1:0] : acc_q[DWIDTH-1:0];
    if (dz_q) quo_fix = '1;
    rem_fix  = neg_a_q ? -acc_q[2*DWIDTH-1:DWIDTH] : acc_q[2*DWIDTH-1:DWIDTH];
  end

  always_comb begin
    state_d = state_q;
    if (bus.em_i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_BUSY;
        S_BUSY:  if (cnt_q == CNT_LAST) state_d = S_FIX;
        S_FIX:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    is_div_d   = is_div_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    busy_d     = (state_d != S_IDLE);
    if (!bus.em_i_flush) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_d    = '0;
            neg_a_d  = rs_neg;
            neg_b_d  = rt_neg;
            is_div_d = op_div;
            dz_d     = op_div && (bus.em_i_data_rt == '0);
            acc_d    = {{DWIDTH{1'b0}}, (op_div ? rs_mag : rt_mag)};
            opb_d    = op_div ? rt_mag : rs_mag;
          end else if (bus.em_i_ce && bus.em_i_op == OP_MTHI) begin
            hi_d = bus.em_i_data_rs;
          end else if (bus.em_i_ce && bus.em_i_op == OP_MTLO) begin
            lo_d = bus.em_i_data_rs;
          end
        end
        S_BUSY: begin
          cnt_d = cnt_q + CW'(1);
          acc_d = is_div_q ? div_next : mul_next;
        end
        S_FIX: begin
          hi_d       = is_div_q ? rem_fix : prod_fix[2*DWIDTH-1:DWIDTH];
          lo_d       = is_div_q ? quo_fix : prod_fix[DWIDTH-1:0];
          done_d     = 1'b1;
          div_zero_d = is_div_q && dz_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge em_i_clk or posedge em_i_rst) begin
    if (em_i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      is_div_q   <= is_div_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.em_o_busy     = busy_q;
  assign bus.em_o_done     = done_q;
  assign bus.em_o_div_zero = div_zero_q;
  assign bus.em_o_hi       = hi_q;
  assign bus.em_o_lo       = lo_q;
endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: STEP=1 and STEP=4 instances against an arithmetic model,
// plus directed vectors with hand-computed results.
module tb_execute_muldiv;
  localparam int W = 32;
  localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                         DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  execute_muldiv_if #(.DWIDTH(W)) ifa ();
  execute_muldiv_if #(.DWIDTH(W)) ifb ();

  execute_muldiv #(.DWIDTH(W), .STEP(1)) dut_a (.em_i_clk(clk), .em_i_rst(rst), .bus(ifa.slave));
  execute_muldiv #(.DWIDTH(W), .STEP(4)) dut_b (.em_i_clk(clk), .em_i_rst(rst), .bus(ifb.slave));

  int errors = 0;
  int checks = 0;

  // Model state: architectural HI/LO, pending result and edges left until it lands.
  logic [31:0] m_hi [2];
  logic [31:0] m_lo [2];
  logic [31:0] p_hi [2];
  logic [31:0] p_lo [2];
  logic        p_dz [2];
  logic        m_done [2];
  logic        m_dz [2];
  int          m_left [2];

  function automatic int lat(input int i);
    return (i == 0) ? 33 : 9;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic model_step(input int i, input logic ce, input logic [2:0] op,
                            input logic [31:0] rs, input logic [31:0] rt, input logic fl);
    longint      sp;
    logic [63:0] up;
    m_done[i] = 1'b0;
    m_dz[i]   = 1'b0;
    if (fl) begin
      m_left[i] = 0;
    end else if (m_left[i] > 0) begin
      m_left[i]--;
      if (m_left[i] == 0) begin
        m_hi[i]   = p_hi[i];
        m_lo[i]   = p_lo[i];
        m_done[i] = 1'b1;
        m_dz[i]   = p_dz[i];
      end
    end else if (ce) begin
      p_dz[i] = 1'b0;
      case (op)
        MULT: begin
          sp = longint'($signed(rs)) * longint'($signed(rt));
          up = 64'(sp);
          {p_hi[i], p_lo[i]} = up;
          m_left[i] = lat(i);
        end
        MULTU: begin
          up = {32'd0, rs} * {32'd0, rt};
          {p_hi[i], p_lo[i]} = up;
          m_left[i] = lat(i);
        end
        DIV, DIVU: begin
          if (rt == 32'd0) begin
            p_lo[i] = 32'hFFFF_FFFF;
            p_hi[i] = rs;
            p_dz[i] = 1'b1;
          end else if (op == DIV && rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
            p_lo[i] = 32'h8000_0000;
            p_hi[i] = 32'd0;
          end else if (op == DIV) begin
            p_lo[i] = 32'($signed(rs) / $signed(rt));
            p_hi[i] = 32'($signed(rs) % $signed(rt));
          end else begin
            p_lo[i] = rs / rt;
            p_hi[i] = rs % rt;
          end
          m_left[i] = lat(i);
        end
        MTHI: m_hi[i] = rs;
        MTLO: m_lo[i] = rs;
        default: ;
      endcase
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_hi[i] = '0; m_lo[i] = '0; p_hi[i] = '0; p_lo[i] = '0; p_dz[i] = 1'b0;
        m_done[i] = 1'b0; m_dz[i] = 1'b0; m_left[i] = 0;
      end
    end else begin
      model_step(0, ifa.em_i_ce, ifa.em_i_op, ifa.em_i_data_rs, ifa.em_i_data_rt, ifa.em_i_flush);
      model_step(1, ifb.em_i_ce, ifb.em_i_op, ifb.em_i_data_rs, ifb.em_i_data_rt, ifb.em_i_flush);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("a_busy", ifa.em_o_busy, m_left[0] != 0);
      check("a_done", ifa.em_o_done, m_done[0]);
      check("a_div_zero", ifa.em_o_div_zero, m_dz[0]);
      check("a_hi", ifa.em_o_hi, m_hi[0]);
      check("a_lo", ifa.em_o_lo, m_lo[0]);
      check("b_busy", ifb.em_o_busy, m_left[1] != 0);
      check("b_done", ifb.em_o_done, m_done[1]);
      check("b_div_zero", ifb.em_o_div_zero, m_dz[1]);
      check("b_hi", ifb.em_o_hi, m_hi[1]);
      check("b_lo", ifb.em_o_lo, m_lo[1]);
    end
  end

  function automatic logic get_busy(input int i);
    return (i == 0) ? ifa.em_o_busy : ifb.em_o_busy;
  endfunction
  function automatic logic get_done(input int i);
    return (i == 0) ? ifa.em_o_done : ifb.em_o_done;
  endfunction
  function automatic logic get_dz(input int i);
    return (i == 0) ? ifa.em_o_div_zero : ifb.em_o_div_zero;
  endfunction
  function automatic logic [31:0] get_hi(input int i);
    return (i == 0) ? ifa.em_o_hi : ifb.em_o_hi;
  endfunction
  function automatic logic [31:0] get_lo(input int i);
    return (i == 0) ? ifa.em_o_lo : ifb.em_o_lo;
  endfunction

  task automatic drive(input int i, input logic ce, input logic [2:0] op,
                       input logic [31:0] rs, input logic [31:0] rt, input logic fl);
    if (i == 0) begin
      ifa.em_i_ce = ce; ifa.em_i_op = op; ifa.em_i_data_rs = rs;
      ifa.em_i_data_rt = rt; ifa.em_i_flush = fl;
    end else begin
      ifb.em_i_ce = ce; ifb.em_i_op = op; ifb.em_i_data_rs = rs;
      ifb.em_i_data_rt = rt; ifb.em_i_flush = fl;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input string tag);
    $display("txn inst%0d %s op=%0d rs=%h rt=%h", i, tag, op, rs, rt);
    drive(i, 1'b1, op, rs, rt, 1'b0);
    tick();
    drive(i, 1'b0, NOP, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic wait_done(input int i, input int n0, output int edges,
                           output int busy_cnt, output logic dz);
    edges    = n0;
    busy_cnt = get_busy(i) ? 1 : 0;
    dz       = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      edges++;
      if (get_done(i)) begin
        dz = get_dz(i);
        return;
      end
      if (get_busy(i)) busy_cnt++;
    end
    checks++;
    errors++;
    $display("FAIL wait_done inst%0d: no done within 100 edges, required after %0d", i, lat(i));
  endtask

  task automatic run_op(input int i, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz, input string tag);
    int   edges, bc;
    logic dz;
    issue(i, op, rs, rt, tag);
    wait_done(i, 0, edges, bc, dz);
    check({tag, "_latency"}, edges, lat(i));
    check({tag, "_busy_cycles"}, bc, lat(i));
    check({tag, "_busy_at_done"}, get_busy(i), 1'b0);
    check({tag, "_hi"}, get_hi(i), exp_hi);
    check({tag, "_lo"}, get_lo(i), exp_lo);
    check({tag, "_div_zero"}, dz, exp_dz);
  endtask

  initial begin
    int   edges, bc, done_cnt;
    logic dz;
    drive(0, 1'b0, NOP, 32'd0, 32'd0, 1'b0);
    drive(1, 1'b0, NOP, 32'd0, 32'd0, 1'b0);
    #2;
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", get_busy(i), 1'b0);
      check("rst_done", get_done(i), 1'b0);
      check("rst_div_zero", get_dz(i), 1'b0);
      check("rst_hi", get_hi(i), 32'd0);
      check("rst_lo", get_lo(i), 32'd0);
    end
    #10 rst = 1'b0;
    tick();

    run_op(0, MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg3x7");
    run_op(0, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
    run_op(0, DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg7by2");
    run_op(0, DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, 1'b1, "divu_by0");
    run_op(0, DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, "div_ovf");
    run_op(0, DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, "div_neg5by0");
    run_op(0, DIV,   32'd100,       32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFF2, 1'b0, "div_100byneg7");

    // Flush ten cycles into a divide.
    issue(0, MTHI, 32'h0000_1234, 32'd0, "mthi");
    check("mthi_hi", get_hi(0), 32'h0000_1234);
    issue(0, DIVU, 32'd100, 32'd3, "divu_flushed");
    repeat (9) tick();
    $display("txn inst0 flush");
    drive(0, 1'b0, NOP, 32'd0, 32'd0, 1'b1);
    tick();
    drive(0, 1'b0, NOP, 32'd0, 32'd0, 1'b0);
    check("flush_busy", get_busy(0), 1'b0);
    check("flush_hi", get_hi(0), 32'h0000_1234);
    done_cnt = 0;
    repeat (40) begin
      tick();
      if (get_done(0)) done_cnt++;
    end
    check("flush_no_done", done_cnt, 0);
    run_op(0, MULT, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, "mult_2x3");

    // Flush in the same cycle as an MTLO: nothing is written.
    $display("txn inst0 mtlo_with_flush rs=%h", 32'hDEAD_BEEF);
    drive(0, 1'b1, MTLO, 32'hDEAD_BEEF, 32'd0, 1'b1);
    tick();
    drive(0, 1'b0, NOP, 32'd0, 32'd0, 1'b0);
    check("flush_mtlo_lo", get_lo(0), 32'd6);

    // STEP=4 instance, with an MTLO presented while busy.
    issue(1, MULTU, 32'd12345, 32'd678, "multu_step4");
    $display("txn inst1 mtlo_while_busy rs=%h", 32'h0000_DEAD);
    drive(1, 1'b1, MTLO, 32'h0000_DEAD, 32'd0, 1'b0);
    tick();
    tick();
    drive(1, 1'b0, NOP, 32'd0, 32'd0, 1'b0);
    wait_done(1, 2, edges, bc, dz);
    check("multu_step4_latency", edges, 9);
    check("multu_step4_hi", get_hi(1), 32'd0);
    check("multu_step4_lo", get_lo(1), 32'd8369910);
    check("multu_step4_div_zero", dz, 1'b0);
    run_op(1, DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_step4");
    run_op(1, DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, "divu0_step4");

    // Asynchronous reset in the middle of operations on both instances.
    issue(1, MULTU, 32'd1000, 32'd1000, "multu_reset_b");
    issue(0, MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_reset_a");
    repeat (3) tick();
    $display("txn reset asserted");
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("midrst_busy", get_busy(i), 1'b0);
      check("midrst_done", get_done(i), 1'b0);
      check("midrst_div_zero", get_dz(i), 1'b0);
      check("midrst_hi", get_hi(i), 32'd0);
      check("midrst_lo", get_lo(i), 32'd0);
    end
    #20 rst = 1'b0;
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion within 200000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
